// File: rtl/pcm_stereo_feeder.sv
// pcm_stereo_feeder: paced volume/offset-binary converter feeding the PCM->PWM FIFO.
// Define PCM_FEEDER_DITHER_EN to add LFSR dither ahead of the 8-bit truncation.
module pcm_stereo_feeder #(
    parameter int CLK_DIV = 1000
) (
    input  logic        clk_pcm,
    input  logic        aclr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_left,
    input  logic [15:0] in_right,
    input  logic [3:0]  volume,
    output logic [15:0] stereo_pcm,
    output logic        stereo_pcm_rdy,
    input  logic        fifo_full,
    output logic [7:0]  underrun_cnt,
    output logic [7:0]  overrun_cnt
);
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {EMPTY, HELD, STALL} state_t;

    state_t        state;
    state_t        state_nx;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          wr;
    logic          cap;
    logic          un_inc;
    logic          ov_inc;
    logic [15:0]   hold_l;
    logic [15:0]   hold_r;
    logic [15:0]   v_l;
    logic [15:0]   v_r;

    function automatic logic [15:0] scale(input logic [15:0] s, input logic [3:0] vol);
        logic signed [19:0] s20;
        logic signed [19:0] g20;
        logic signed [19:0] p;
        s20 = 20'(signed'(s));
        g20 = 20'({1'b0, vol}) + 20'sd1;
        p   = s20 * g20;
        return 16'(p >>> 4);
    endfunction

    function automatic logic [7:0] offset8(input logic [15:0] v);
        return 8'(v >> 8) ^ 8'h80;
    endfunction

    assign tick     = div_cnt == DW'(CLK_DIV - 1);
    assign in_ready = state == EMPTY;

    always_ff @(posedge clk_pcm or negedge aclr) begin
        if (!aclr) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge clk_pcm or negedge aclr) begin
        if (!aclr) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY:   if (in_valid) state_nx = HELD;
            HELD:    if (tick) state_nx = fifo_full ? STALL : EMPTY;
            STALL:   if (!fifo_full) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    always_comb begin
        wr     = 1'b0;
        cap    = 1'b0;
        un_inc = 1'b0;
        ov_inc = 1'b0;
        unique case (state)
            EMPTY: begin
                cap    = in_valid;
                un_inc = tick;
            end
            HELD:  wr = tick && !fifo_full;
            STALL: begin
                wr     = !fifo_full;
                ov_inc = tick && fifo_full;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_pcm or negedge aclr) begin
        if (!aclr) begin
            hold_l       <= '0;
            hold_r       <= '0;
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
        end else begin
            if (cap) begin
                hold_l <= in_left;
                hold_r <= in_right;
            end
            if (un_inc && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
            if (ov_inc && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

`ifdef PCM_FEEDER_DITHER_EN
    logic [15:0] lfsr;

    // Positive-only dither, so only the top end can overflow.
    function automatic logic [15:0] dither(input logic [15:0] v, input logic [7:0] d);
        logic signed [16:0] sum;
        sum = 17'(signed'(v)) + 17'(d);
        return (sum > 17'sd32767) ? 16'h7FFF : 16'(sum);
    endfunction

    always_ff @(posedge clk_pcm or negedge aclr) begin
        if (!aclr) begin
            lfsr <= 16'hACE1;
        end else if (wr) begin
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    assign v_l = dither(scale(hold_l, volume), lfsr[7:0]);
    assign v_r = dither(scale(hold_r, volume), lfsr[15:8]);
`else
    assign v_l = scale(hold_l, volume);
    assign v_r = scale(hold_r, volume);
`endif

    always_ff @(posedge clk_pcm or negedge aclr) begin
        if (!aclr) begin
            stereo_pcm     <= '0;
            stereo_pcm_rdy <= 1'b0;
        end else begin
            stereo_pcm_rdy <= wr;
            if (wr) stereo_pcm <= {offset8(v_r), offset8(v_l)};
        end
    end
endmodule

// File: tb/tb_pcm_stereo_feeder.sv
// tb_pcm_stereo_feeder: random and directed stimulus against a sample-level model.
// Honours PCM_FEEDER_DITHER_EN in the reference model as well.
module tb_pcm_stereo_feeder;
    localparam int CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic [3:0]  volume = 4'd15;
    logic [15:0] stereo_pcm;
    logic        stereo_pcm_rdy;
    logic        fifo_full = 1'b0;
    logic [7:0]  underrun_cnt;
    logic [7:0]  overrun_cnt;

    pcm_stereo_feeder #(.CLK_DIV(CLK_DIV)) dut (
        .clk_pcm        (clk),
        .aclr           (aclr),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_left        (in_left),
        .in_right       (in_right),
        .volume         (volume),
        .stereo_pcm     (stereo_pcm),
        .stereo_pcm_rdy (stereo_pcm_rdy),
        .fifo_full      (fifo_full),
        .underrun_cnt   (underrun_cnt),
        .overrun_cnt    (overrun_cnt)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int pulses[$];

    // Reference state: a single sample slot, a stalled flag, the
    // pending FIFO word and the two saturating counters.
    int          n;
    bit          m_have;
    bit          m_stall;
    bit          m_tick;
    logic [15:0] m_l, m_r;
    logic [15:0] m_pcm;
    bit          m_rdy;
    int          m_un, m_ov;
    logic [15:0] m_lfsr;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] conv(input logic [15:0] s, input logic [3:0] vol,
                                        input int d);
        int v;
        v = ($signed(s) * (int'(vol) + 1)) >>> 4;
        v = v + d;
        if (v > 32767) v = 32767;
        return 8'(((v & 32'hFFFF) >> 8) ^ 32'h80);
    endfunction

    task automatic model_reset();
        n = 0; m_have = 0; m_stall = 0; m_tick = 0;
        m_l = '0; m_r = '0; m_pcm = '0; m_rdy = 0;
        m_un = 0; m_ov = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic model_edge();
        bit wr;
        int dl, dr;
        m_tick = (n % CLK_DIV) == CLK_DIV - 1;
        n++;
        wr = 0;
        if (!m_have) begin
            if (m_tick) m_un = (m_un < 255) ? m_un + 1 : 255;
            if (in_valid) begin
                m_have = 1; m_l = in_left; m_r = in_right;
            end
        end else if (!m_stall) begin
            if (m_tick && !fifo_full) begin
                wr = 1; m_have = 0;
            end else if (m_tick) begin
                m_stall = 1;
            end
        end else begin
            if (!fifo_full) begin
                wr = 1; m_have = 0; m_stall = 0;
            end else if (m_tick) begin
                m_ov = (m_ov < 255) ? m_ov + 1 : 255;
            end
        end
        m_rdy = wr;
        if (wr) begin
            dl = 0; dr = 0;
`ifdef PCM_FEEDER_DITHER_EN
            dl = int'(m_lfsr[7:0]);
            dr = int'(m_lfsr[15:8]);
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
`endif
            m_pcm = {conv(m_r, volume, dr), conv(m_l, volume, dl)};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("rdy", 16'(stereo_pcm_rdy), 16'(m_rdy));
        chk("pcm", stereo_pcm, m_pcm);
        chk("in_ready", 16'(in_ready), 16'(!m_have));
        chk("underrun", 16'(underrun_cnt), 16'(m_un));
        chk("overrun", 16'(overrun_cnt), 16'(m_ov));
        if (stereo_pcm_rdy) pulses.push_back(cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 aclr = 1'b0;
        #1;
        model_reset();
        chk("rst_rdy", 16'(stereo_pcm_rdy), 16'h0);
        chk("rst_pcm", stereo_pcm, 16'h0);
        chk("rst_ready", 16'(in_ready), 16'h1);
        chk("rst_un", 16'(underrun_cnt), 16'h0);
        chk("rst_ov", 16'(overrun_cnt), 16'h0);
        in_valid  = 1'b0;
        fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        aclr = 1'b1;
    endtask

    task automatic chk_pcm(input string tag, input logic [15:0] exp);
`ifdef PCM_FEEDER_DITHER_EN
        chk(tag, stereo_pcm, m_pcm);
`else
        chk(tag, stereo_pcm, exp);
`endif
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r);
        in_left = l; in_right = r; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_rdy(input string tag, input logic [15:0] exp);
        bit seen = 0;
        for (int i = 0; i < 3 * CLK_DIV && !seen; i++) begin
            step();
            seen = stereo_pcm_rdy;
        end
        if (!seen) chk({tag, "_timeout"}, 16'h0, 16'h1);
        else chk_pcm(tag, exp);
    endtask

    task automatic drain();
        in_valid = 1'b0; fifo_full = 1'b0;
        repeat (2 * CLK_DIV) step();
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 11))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int ov0, k, r1, r2;
        model_reset();
        do_reset();

        volume = 4'd15;
        send(16'h7FFF, 16'h8000);
        wait_rdy("conv_max", 16'h00FF);
        send(16'h0000, 16'h0000);
        wait_rdy("conv_zero", 16'h8080);
        send(16'h00FF, 16'h00FF);
        wait_rdy("conv_small", 16'h8080);
        send(16'h7FFF, 16'h7FFF);
        wait_rdy("conv_nowrap", 16'hFFFF);
        volume = 4'd7;
        send(16'h4000, 16'hC000);
        wait_rdy("vol7", 16'h60A0);

        drain();
        pulses.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_left = 16'($urandom); in_right = 16'($urandom);
            step();
        end
        in_valid = 1'b0;
        chk("pace_cnt", 16'(pulses.size() >= 4), 16'h1);
        for (int i = 1; i < pulses.size(); i++)
            chk("pace_gap", 16'(pulses[i] - pulses[i-1]), 16'(CLK_DIV));

        drain();
        k = 0;
        while (!m_tick && k < 2 * CLK_DIV) begin
            step(); k++;
        end
        chk("align", 16'(m_tick), 16'h1);
        volume = 4'd7;
        send(16'h4000, 16'hC000);
        repeat (5) step();
        ov0 = overrun_cnt;
        fifo_full = 1'b1;
        repeat (20) step();
        fifo_full = 1'b0;
        step();
        chk("bp_rdy", 16'(stereo_pcm_rdy), 16'h1);
        chk_pcm("bp_data", 16'h60A0);
        chk("bp_ovr", 16'(int'(overrun_cnt) - ov0), 16'h2);

        pulses.delete();
        repeat (300 * CLK_DIV) step();
        chk("un_sat", 16'(underrun_cnt), 16'h00FF);
        chk("un_no_rdy", 16'(pulses.size()), 16'h0);

        send(16'h1234, 16'h5678);
        fifo_full = 1'b1;
        repeat (3 * CLK_DIV) step();
        chk("stall_ov", 16'(overrun_cnt != 0), 16'h1);
        do_reset();
        repeat (CLK_DIV) step();
        chk("rst_first_un", 16'(underrun_cnt), 16'h1);

        r1 = $urandom_range(800, 1200);
        r2 = $urandom_range(2000, 2400);
        for (int i = 0; i < 3000; i++) begin
            if (i == r1 || i == r2) do_reset();
            in_valid = $urandom_range(0, 99) < 40;
            if ($urandom_range(0, 9) == 0) fifo_full = ~fifo_full;
            volume   = 4'($urandom);
            in_left  = pick();
            in_right = pick();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
